ro_puf_controller: RTL and testbench

- Sequencer for the RO PUF datapath: walks a list of oscillator-pair challenges, drives sel1/sel2, enable and reset of the datapath, and times a fixed measurement window per pair.
- Compares count_1 vs count_2 after each window and assembles an N_BITS response word.
- Sits between the host/test logic and the RO PUF top level; it is the only driver of the datapath's sel1, sel2, enable and reset.

---
 rtl/ro_puf_controller.sv | 163 ++++++++++++++++
 tb/tb_ro_puf_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_controller.sv
// Sequencer for the RO PUF datapath: walks N_BITS oscillator-pair challenges,
// times a fixed enable window per pair and folds count comparisons into a response word.
module ro_puf_controller #(
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8,
  parameter int WINDOW = 200,
  parameter int N_BITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [N_BITS*2*SEL_W-1:0]  challenge,
  input  logic [CNT_W-1:0]           count_1,
  input  logic [CNT_W-1:0]           count_2,
  output logic [SEL_W-1:0]           sel1,
  output logic [SEL_W-1:0]           sel2,
  output logic                       ro_enable,
  output logic                       ro_reset,
  output logic                       busy,
  output logic                       done,
  output logic [N_BITS-1:0]          response,
  output logic                       tie,
  output logic                       saturated
);

  localparam int CH_W  = N_BITS * 2 * SEL_W;
  localparam int TMR_W = (WINDOW > 1) ? $clog2(WINDOW + 1) : 1;
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [TMR_W-1:0] RUN_LAST = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] TWO_LAST = TMR_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic [CH_W-1:0]    chal_q;
  logic               cnt_gt;
  logic               cnt_eq;
  logic               cnt_sat;

  // Pair i occupies [i*2*SEL_W +: 2*SEL_W] as {sel1_i, sel2_i}.
  function automatic logic [SEL_W-1:0] pair_sel1(input logic [CH_W-1:0] ch,
                                                  input logic [IDX_W-1:0] i);
    return ch[int'(i)*2*SEL_W + SEL_W +: SEL_W];
  endfunction

  function automatic logic [SEL_W-1:0] pair_sel2(input logic [CH_W-1:0] ch,
                                                  input logic [IDX_W-1:0] i);
    return ch[int'(i)*2*SEL_W +: SEL_W];
  endfunction

  assign idx_nxt = idx + IDX_W'(1);
  assign cnt_gt  = (count_1 > count_2);
  assign cnt_eq  = (count_1 == count_2);
  assign cnt_sat = (count_1 == '1) || (count_2 == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      chal_q    <= '0;
      sel1      <= '0;
      sel2      <= '0;
      ro_enable <= 1'b0;
      ro_reset  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      response  <= '0;
      tie       <= 1'b0;
      saturated <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ro_reset  <= 1'b1;
          ro_enable <= 1'b0;
          if (start) begin
            chal_q    <= challenge;
            response  <= '0;
            tie       <= 1'b0;
            saturated <= 1'b0;
            idx       <= '0;
            timer     <= '0;
            sel1      <= pair_sel1(challenge, '0);
            sel2      <= pair_sel2(challenge, '0);
            busy      <= 1'b1;
            state     <= CLEAR;
          end
        end

        CLEAR: begin
          if (timer == TWO_LAST) begin
            timer     <= '0;
            ro_reset  <= 1'b0;
            ro_enable <= 1'b1;
            state     <= RUN;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        RUN: begin
          if (timer == RUN_LAST) begin
            timer     <= '0;
            ro_enable <= 1'b0;
            state     <= SETTLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        // Ripple counters need a couple of cycles to settle after enable drops.
        SETTLE: begin
          if (timer == TWO_LAST) begin
            timer <= '0;
            state <= COMPARE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        COMPARE: begin
          response[idx] <= cnt_gt;
          if (cnt_eq) tie <= 1'b1;
          if (cnt_sat) saturated <= 1'b1;
          ro_reset <= 1'b1;
          if (idx == IDX_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx_nxt;
            sel1  <= pair_sel1(chal_q, idx_nxt);
            sel2  <= pair_sel2(chal_q, idx_nxt);
            state <= CLEAR;
          end
        end

        DONE: begin
          ro_reset <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_controller.sv
// Bench for ro_puf_controller: table of challenge/count vectors driven through a
// count stub keyed on sel1, plus hand-written reset and start-handling sequences.
module tb_ro_puf_controller;

  localparam int SEL_W      = 3;
  localparam int CNT_W      = 8;
  localparam int WINDOW     = 16;
  localparam int N_BITS     = 4;
  localparam int PAIR_CYC   = WINDOW + 5;
  localparam int DONE_EDGES = N_BITS * PAIR_CYC + 1;
  localparam int NVEC       = 4;

  logic                      clk;
  logic                      reset;
  logic                      start;
  logic [N_BITS*2*SEL_W-1:0] challenge;
  logic [CNT_W-1:0]          count_1;
  logic [CNT_W-1:0]          count_2;
  logic [SEL_W-1:0]          sel1;
  logic [SEL_W-1:0]          sel2;
  logic                      ro_enable;
  logic                      ro_reset;
  logic                      busy;
  logic                      done;
  logic [N_BITS-1:0]         response;
  logic                      tie;
  logic                      saturated;

  ro_puf_controller #(
    .SEL_W (SEL_W),
    .CNT_W (CNT_W),
    .WINDOW(WINDOW),
    .N_BITS(N_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .challenge(challenge),
    .count_1  (count_1),
    .count_2  (count_2),
    .sel1     (sel1),
    .sel2     (sel2),
    .ro_enable(ro_enable),
    .ro_reset (ro_reset),
    .busy     (busy),
    .done     (done),
    .response (response),
    .tie      (tie),
    .saturated(saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stub: counts are looked up by the sel1 value currently selected.
  logic [CNT_W-1:0] c1_tab [8];
  logic [CNT_W-1:0] c2_tab [8];
  assign count_1 = c1_tab[sel1];
  assign count_2 = c2_tab[sel1];

  typedef struct packed {
    logic [N_BITS-1:0][SEL_W-1:0] s1;
    logic [N_BITS-1:0][SEL_W-1:0] s2;
    logic [N_BITS-1:0][CNT_W-1:0] c1;
    logic [N_BITS-1:0][CNT_W-1:0] c2;
    logic [N_BITS-1:0]            resp;
    logic                         tie;
    logic                         sat;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_vec(input int k);
    for (int i = 0; i < N_BITS; i++) begin
      c1_tab[vecs[k].s1[i]] = vecs[k].c1[i];
      c2_tab[vecs[k].s1[i]] = vecs[k].c2[i];
      challenge[i*2*SEL_W +: 2*SEL_W] = {vecs[k].s1[i], vecs[k].s2[i]};
    end
  endtask

  // Starts a run of vector k and follows it to done, checking sequencing and results.
  task automatic run_vec(input int k, input bit pulse_mid, input bit hold);
    int               edges;
    int               pair;
    int               en_cnt;
    int               sel_bad;
    int               sel_err;
    int               en_len [N_BITS];
    bit               got_done;
    logic [SEL_W-1:0] p_s1;
    logic [SEL_W-1:0] p_s2;
    logic             p_busy;
    logic             p_rr;
    logic             p_en;
    logic             d_busy;
    logic             d_rr;
    for (int i = 0; i < N_BITS; i++) en_len[i] = 0;
    @(negedge clk);
    load_vec(k);
    start    = 1'b1;
    p_s1     = sel1;
    p_s2     = sel2;
    p_busy   = busy;
    p_rr     = ro_reset;
    p_en     = 1'b0;
    edges    = 0;
    pair     = 0;
    en_cnt   = 0;
    sel_bad  = 0;
    sel_err  = 0;
    got_done = 1'b0;
    d_busy   = 1'b1;
    d_rr     = 1'b0;
    while (!got_done && edges < DONE_EDGES + 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!hold) start = (pulse_mid && edges == 30);
      if ((sel1 !== p_s1 || sel2 !== p_s2) && p_busy && !(ro_reset && !p_rr)) sel_bad++;
      if (ro_enable) begin
        en_cnt++;
        if (!p_en && pair < N_BITS) begin
          if (sel1 !== vecs[k].s1[pair] || sel2 !== vecs[k].s2[pair]) sel_err++;
        end
      end else if (p_en) begin
        if (pair < N_BITS) en_len[pair] = en_cnt;
        pair++;
        en_cnt = 0;
      end
      if (done) begin
        got_done = 1'b1;
        d_busy   = busy;
        d_rr     = ro_reset;
      end
      p_s1   = sel1;
      p_s2   = sel2;
      p_busy = busy;
      p_rr   = ro_reset;
      p_en   = ro_enable;
    end
    check($sformatf("v%0d done_seen", k), 32'(got_done), 32'd1);
    check($sformatf("v%0d done_latency", k), 32'(edges), 32'(DONE_EDGES));
    check($sformatf("v%0d response", k), 32'(response), 32'(vecs[k].resp));
    check($sformatf("v%0d tie", k), 32'(tie), 32'(vecs[k].tie));
    check($sformatf("v%0d saturated", k), 32'(saturated), 32'(vecs[k].sat));
    check($sformatf("v%0d busy_at_done", k), 32'(d_busy), 32'd0);
    check($sformatf("v%0d ro_reset_at_done", k), 32'(d_rr), 32'd1);
    check($sformatf("v%0d enable_windows", k), 32'(pair), 32'(N_BITS));
    for (int i = 0; i < N_BITS; i++)
      check($sformatf("v%0d enable_len_pair%0d", k, i), 32'(en_len[i]), 32'(WINDOW));
    check($sformatf("v%0d sel_values", k), 32'(sel_err), 32'd0);
    check($sformatf("v%0d sel_stable", k), 32'(sel_bad), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ro_reset"}, 32'(ro_reset), 32'd1);
    check({tag, " ro_enable"}, 32'(ro_enable), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " response"}, 32'(response), 32'd0);
    check({tag, " sel1"}, 32'(sel1), 32'd0);
    check({tag, " sel2"}, 32'(sel2), 32'd0);
    check({tag, " tie"}, 32'(tie), 32'd0);
    check({tag, " saturated"}, 32'(saturated), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 8; i++) begin
      c1_tab[i] = '0;
      c2_tab[i] = '0;
    end

    // Vector 0: alternating winners -> 4'b0101.
    vecs[0].s1 = {3'd6, 3'd4, 3'd2, 3'd0};
    vecs[0].s2 = {3'd7, 3'd5, 3'd3, 3'd1};
    vecs[0].c1 = {8'd30, 8'd40, 8'd30, 8'd40};
    vecs[0].c2 = {8'd40, 8'd30, 8'd40, 8'd30};
    vecs[0].resp = 4'b0101; vecs[0].tie = 1'b0; vecs[0].sat = 1'b0;
    // Vector 1: pair 2 ties 55/55, pair 3 saturates at 255.
    vecs[1].s1 = {3'd6, 3'd4, 3'd2, 3'd0};
    vecs[1].s2 = {3'd7, 3'd5, 3'd3, 3'd1};
    vecs[1].c1 = {8'd255, 8'd55, 8'd5, 8'd10};
    vecs[1].c2 = {8'd10, 8'd55, 8'd10, 8'd5};
    vecs[1].resp = 4'b1001; vecs[1].tie = 1'b1; vecs[1].sat = 1'b1;
    // Vector 2: sel1==sel2 pairs, saturation on count_2 only, off-by-one compare.
    vecs[2].s1 = {3'd5, 3'd7, 3'd1, 3'd3};
    vecs[2].s2 = {3'd2, 3'd7, 3'd0, 3'd3};
    vecs[2].c1 = {8'd128, 8'd0, 8'd200, 8'd20};
    vecs[2].c2 = {8'd127, 8'd255, 8'd100, 8'd20};
    vecs[2].resp = 4'b1010; vecs[2].tie = 1'b1; vecs[2].sat = 1'b1;
    // Vector 3: all ones, sticky flags must be cleared from the previous run.
    vecs[3].s1 = {3'd3, 3'd2, 3'd1, 3'd0};
    vecs[3].s2 = {3'd4, 3'd5, 3'd6, 3'd7};
    vecs[3].c1 = {8'd9, 8'd9, 8'd9, 8'd9};
    vecs[3].c2 = {8'd8, 8'd8, 8'd8, 8'd8};
    vecs[3].resp = 4'b1111; vecs[3].tie = 1'b0; vecs[3].sat = 1'b0;

    reset     = 1'b1;
    start     = 1'b0;
    challenge = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      run_vec(k, (k == 1), 1'b0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d done_pulse_width", k), 32'(done), 32'd0);
      check($sformatf("v%0d response_hold", k), 32'(response), 32'(vecs[k].resp));
    end

    // Reset during RUN of pair 1, then a fresh full run.
    @(negedge clk);
    load_vec(0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    check("midrun in_run", 32'(ro_enable), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrun");
    reset = 1'b0;
    run_vec(1, 1'b0, 1'b0);

    // start held high: the next run is accepted on the IDLE cycle after DONE.
    run_vec(2, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("hold idle_after_done busy", 32'(busy), 32'd0);
    check("hold idle_after_done done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("hold reaccept busy", 32'(busy), 32'd1);
    check("hold reaccept cleared", 32'({response, tie, saturated}), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
